// File: rtl/ks_pkg.sv
// ks_pkg: shared limb width, FSM states and the ks16 pin-map helpers.
package ks_pkg;
  localparam int LIMB_W = 16;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  function automatic logic [31:0] pack_ks16_in(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] r;
    for (int i = 0; i < 16; i++) begin
      r[15-i] = a[i];
      r[31-i] = b[i];
    end
    return r;
  endfunction
  function automatic logic [16:0] unpack_ks16_out(input logic [16:0] o);
    logic [16:0] r;
    for (int i = 0; i < 16; i++) r[i] = o[16-i];
    r[16] = o[0];
    return r;
  endfunction
endpackage

// File: rtl/ks_limb_adder_seq_ks16.sv
// ks16: combinational 16-bit Kogge-Stone adder with bit-reversed pin map, carry on out_o[0].
module ks16 (
  input  logic [31:0] in_i,
  output logic [16:0] out_o
);
  logic [15:0] a, b, g, p, s;
  genvar i;
  for (i = 0; i < 16; i++) begin : g_pin
    assign a[i] = in_i[15-i];
    assign b[i] = in_i[31-i];
    assign out_o[16-i] = s[i];
  end
  // Four prefix levels at distance 1,2,4,8; low bits need no propagate once their generate is final.
  always_comb begin
    g = a & b;
    p = a ^ b;
    for (int k = 0; k < 4; k++) begin
      g = g | (p & (g << (1 << k)));
      p = p & (p << (1 << k));
    end
  end
  assign s = (a ^ b) ^ {g[14:0], 1'b0};
  assign out_o[0] = g[15];
endmodule

// File: rtl/ks_limb_adder_seq.sv
// ks_limb_adder_seq: multi-limb adder, one 16-bit ks16 limb per cycle, LSB limb first.
module ks_limb_adder_seq
  import ks_pkg::*;
#(
  parameter int LIMBS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LIMBS*16-1:0]   in_a,
  input  logic [LIMBS*16-1:0]   in_b,
  input  logic                  in_cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LIMBS*16-1:0]   out_sum,
  output logic                  out_cout
);
  localparam int W = LIMBS * LIMB_W;
  localparam int IW = $clog2(LIMBS + 1);
  state_e state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IW-1:0] idx_q, idx_d;
  logic cy_q, cy_d, cn, last;
  logic [16:0] ks_out, ks_cs;
  logic [LIMB_W-1:0] limb;
  ks16 u_ks16 (
    .in_i (pack_ks16_in(a_q[LIMB_W-1:0], b_q[LIMB_W-1:0])),
    .out_o(ks_out)
  );
  assign ks_cs = unpack_ks16_out(ks_out);
  // The incoming carry is folded in with an incrementer after the slice.
  assign limb = ks_cs[15:0] + LIMB_W'(cy_q);
  assign cn = ks_cs[16] | (cy_q & (&ks_cs[15:0]));
  assign last = idx_q == IW'(LIMBS - 1);
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    cy_d = cy_q;
    idx_d = idx_q;
    sum_d = sum_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = RUN;
        a_d = in_a;
        b_d = in_b;
        cy_d = in_cin;
        idx_d = '0;
      end
      RUN: begin
        a_d = a_q >> LIMB_W;
        b_d = b_q >> LIMB_W;
        sum_d = W'({limb, sum_q} >> LIMB_W);
        cy_d = cn;
        idx_d = idx_q + IW'(1);
        state_d = last ? DONE : RUN;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      cy_q <= 1'b0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      sum_q <= sum_d;
      cy_q <= cy_d;
      idx_q <= idx_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign out_sum = sum_q;
  assign out_cout = cy_q;
endmodule

// File: tb/tb_ks_limb_adder_seq.sv
// tb_ks_limb_adder_seq: scoreboard bench for LIMBS=4 (directed + random) and LIMBS=1 (random).
module tb_ks_limb_adder_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, in_valid, in_cin, in_ready, out_valid, out_cout, out_ready;
  logic [63:0] in_a, in_b, out_sum;
  logic rst1, in_valid1, in_cin1, in_ready1, out_valid1, out_cout1;
  logic out_ready1 = 1'b1;
  logic [15:0] in_a1, in_b1, out_sum1;
  bit rand_rdy = 1'b0, rdy_force = 1'b1, rr = 1'b1, done1 = 1'b0;
  int total = 0, bad = 0, cyc = 0, hs = 0;
  logic [64:0] q4[$];
  logic [16:0] q1[$];
  logic [64:0] e4;
  logic [16:0] e1;
  assign out_ready = rand_rdy ? rr : rdy_force;
  ks_limb_adder_seq #(.LIMBS(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout)
  );
  ks_limb_adder_seq #(.LIMBS(1)) dut1 (
    .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1), .in_b(in_b1),
    .in_cin(in_cin1), .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(out_sum1), .out_cout(out_cout1)
  );
  always @(posedge clk) cyc <= cyc + 1;
  initial forever begin
    @(posedge clk);
    #2;
    rr = $urandom_range(0, 2) != 0;
    out_ready1 = $urandom_range(0, 2) != 0;
  end
  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) if (!rst && out_valid && out_ready) begin
    if (q4.size() == 0) begin
      total++;
      bad++;
      $display("FAIL spurious4: got %h expected no result", {out_cout, out_sum});
    end else begin
      e4 = q4.pop_front();
      chk("sum4", 66'({out_cout, out_sum}), 66'(e4));
    end
  end
  always @(negedge clk) if (!rst1 && out_valid1 && out_ready1) begin
    if (q1.size() == 0) begin
      total++;
      bad++;
      $display("FAIL spurious1: got %h expected no result", {out_cout1, out_sum1});
    end else begin
      e1 = q1.pop_front();
      chk("sum1", 66'({out_cout1, out_sum1}), 66'(e1));
    end
  end
  task automatic set_rdy(input bit v);
    @(posedge clk);
    #1 rdy_force = v;
  endtask
  task automatic send4(input logic [63:0] a, input logic [63:0] b, input logic c, input logic [64:0] exp, input bit push);
    int n = 0;
    @(posedge clk);
    #1;
    in_a = a;
    in_b = b;
    in_cin = c;
    in_valid = 1'b1;
    if (push) q4.push_back(exp);
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept4", 66'(in_ready), 66'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    hs = cyc;
  endtask
  task automatic wait_idle4();
    int n = 0;
    while ((q4.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain4", 66'(q4.size()), 66'(0));
  endtask
  initial begin
    int n;
    bit ir_bad;
    logic [63:0] ra, rb;
    logic rc;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_cin = 1'b0;
    #12;
    chk("reset", {in_ready, out_valid, out_cout, out_sum[62:0]}, {1'b1, 1'b0, 1'b0, 63'd0});
    chk("reset_sum_msb", 66'(out_sum[63]), 66'(0));
    @(negedge clk);
    rst = 1'b0;
    send4(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, {1'b1, 64'd0}, 1'b1);
    wait_idle4();
    send4(64'h8000_8000_8000_8000, 64'h8000_8000_8000_8000, 1'b0, {1'b1, 64'h0001_0001_0001_0000}, 1'b1);
    wait_idle4();
    set_rdy(1'b0);
    send4(64'd1, 64'd2, 1'b0, {1'b0, 64'd3}, 1'b1);
    ir_bad = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      if (in_ready) ir_bad = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("latency", 66'(cyc - hs), 66'(4));
    repeat (2) begin
      @(negedge clk);
      if (in_ready) ir_bad = 1'b1;
    end
    chk("in_ready_low", 66'(ir_bad), 66'(0));
    set_rdy(1'b1);
    wait_idle4();
    set_rdy(1'b0);
    send4(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, {1'b0, 64'h2222_2222_2222_2212}, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      in_valid = k == 1;
      in_a = 64'h0BAD_0BAD_0BAD_0BAD;
      in_b = 64'h1111_1111_1111_1111;
      @(negedge clk);
      chk("hold", {out_valid, out_cout, out_sum}, {1'b1, 1'b0, 64'h2222_2222_2222_2212});
    end
    in_valid = 1'b0;
    set_rdy(1'b1);
    wait_idle4();
    repeat (6) @(negedge clk);
    chk("no_extra", 66'(out_valid), 66'(0));
    send4(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 65'd0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("mid_reset", {out_valid, in_ready, out_sum}, {1'b0, 1'b1, 64'd0});
    @(negedge clk);
    rst = 1'b0;
    chk("ready_after_reset", 66'(in_ready), 66'(1));
    send4(64'hFFFF_0000_FFFF_0001, 64'h0000_FFFF_0000_FFFF, 1'b0, {1'b1, 64'd0}, 1'b1);
    wait_idle4();
    rand_rdy = 1'b1;
    for (int k = 0; k < 300; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      send4(ra, rb, rc, 65'(ra) + 65'(rb) + 65'(rc), 1'b1);
    end
    wait_idle4();
    rand_rdy = 1'b0;
    n = 0;
    while (!done1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("done1", 66'(done1), 66'(1));
    chk("drain1", 66'(q1.size()), 66'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    int n;
    logic [15:0] a, b;
    logic c;
    rst1 = 1'b1;
    in_valid1 = 1'b0;
    in_a1 = '0;
    in_b1 = '0;
    in_cin1 = 1'b0;
    #12;
    @(negedge clk);
    rst1 = 1'b0;
    for (int k = 0; k < 400; k++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      @(posedge clk);
      #1;
      a = 16'($urandom);
      b = 16'($urandom);
      c = 1'($urandom_range(0, 1));
      in_a1 = a;
      in_b1 = b;
      in_cin1 = c;
      in_valid1 = 1'b1;
      q1.push_back(17'(a) + 17'(b) + 17'(c));
      n = 0;
      @(negedge clk);
      while (!in_ready1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready1) chk("accept1", 66'(in_ready1), 66'(1));
      @(posedge clk);
      #1 in_valid1 = 1'b0;
    end
    n = 0;
    while ((q1.size() != 0 || out_valid1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    done1 = 1'b1;
  end
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
